// File: rtl/pipeline_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipeline_pkg;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        LU_STALL  = 2'd1,
        MISS_WAIT = 2'd2
    } hz_state_e;

    localparam int unsigned REG_ZERO   = 0;
    localparam int unsigned WAIT_CNT_W = 16;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use compare between the load in ID/EX and the sources in IF/ID.
module hazard_detect
    import pipeline_pkg::*;
#(
    parameter int unsigned REG_AW = 5
) (
    input  logic              idex_memread_i,
    input  logic [REG_AW-1:0] idex_rt_i,
    input  logic [REG_AW-1:0] ifid_rs_i,
    input  logic [REG_AW-1:0] ifid_rt_i,
    output logic              lu_hazard_o
);

    logic rt_nonzero;
    logic src_match;

    // The zero register is hard-wired, so a load targeting it never produces a value to wait for.
    assign rt_nonzero  = (idex_rt_i != REG_AW'(REG_ZERO));
    assign src_match   = (idex_rt_i == ifid_rs_i) || (idex_rt_i == ifid_rt_i);
    assign lu_hazard_o = idex_memread_i && rt_nonzero && src_match;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller: cache-miss freeze, branch flush, one-bubble load-use stall.
// Optional performance counters are enabled with `define HAZARD_PERF_CNT_EN.
module pipeline_hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int unsigned MISS_TIMEOUT = 64,
    parameter int unsigned REG_AW       = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hit,
    input  logic              mem_access,
    input  logic              idex_memread,
    input  logic [REG_AW-1:0] idex_rt,
    input  logic [REG_AW-1:0] ifid_rs,
    input  logic [REG_AW-1:0] ifid_rt,
    input  logic              branch_taken,
    output logic              pc_en,
    output logic              ifid_en,
    output logic              idex_en,
    output logic              exmem_en,
    output logic              ifid_flush,
    output logic              idex_flush,
`ifdef HAZARD_PERF_CNT_EN
    output logic [31:0]       lu_stall_cnt,
    output logic [31:0]       miss_stall_cnt,
    output logic [31:0]       flush_cnt,
`endif
    output logic              miss_timeout
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_MAX = WAIT_CNT_W'(MISS_TIMEOUT);

    hz_state_e             state_q, state_d;
    logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic                  timeout_q, timeout_d;

    logic miss;
    logic lu_hazard;
    logic lu_stall;
    logic branch_flush;

    hazard_detect #(
        .REG_AW (REG_AW)
    ) u_hazard_detect (
        .idex_memread_i (idex_memread),
        .idex_rt_i      (idex_rt),
        .ifid_rs_i      (ifid_rs),
        .ifid_rt_i      (ifid_rt),
        .lu_hazard_o    (lu_hazard)
    );

    assign miss         = mem_access && !hit;
    assign branch_flush = branch_taken && !miss;
    // Detection is masked only in the bubble cycle; the MISS_WAIT exit cycle re-evaluates the hazard.
    assign lu_stall     = lu_hazard && (state_q != LU_STALL) && !miss && !branch_taken;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    always_comb begin
        state_d    = RUN;
        wait_cnt_d = '0;
        timeout_d  = timeout_q;
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        idex_en    = 1'b1;
        exmem_en   = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;

        if (!rst_n) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_en    = 1'b0;
            exmem_en   = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (miss) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            state_d  = MISS_WAIT;
            if (state_q == MISS_WAIT) begin
                wait_cnt_d = (wait_cnt_q == WAIT_MAX) ? wait_cnt_q : wait_cnt_q + 1'b1;
            end
            if (wait_cnt_d == WAIT_MAX) begin
                timeout_d = 1'b1;
            end
        end else if (branch_flush) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (lu_stall) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
            state_d    = LU_STALL;
        end
    end

    assign miss_timeout = timeout_q && rst_n;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] lu_cnt_q, miss_cnt_q, flush_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lu_cnt_q    <= '0;
            miss_cnt_q  <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (lu_stall && (lu_cnt_q != '1)) begin
                lu_cnt_q <= lu_cnt_q + 1'b1;
            end
            if (miss && (miss_cnt_q != '1)) begin
                miss_cnt_q <= miss_cnt_q + 1'b1;
            end
            if (branch_flush && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + 1'b1;
            end
        end
    end

    assign lu_stall_cnt   = lu_cnt_q;
    assign miss_stall_cnt = miss_cnt_q;
    assign flush_cnt      = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench: dut_a uses the default timeout, dut_b uses MISS_TIMEOUT=4.
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       hit;
    logic       mem_access;
    logic       idex_memread;
    logic [4:0] idex_rt;
    logic [4:0] ifid_rs;
    logic [4:0] ifid_rt;
    logic       branch_taken;

    logic pc_en_a, ifid_en_a, idex_en_a, exmem_en_a, ifid_flush_a, idex_flush_a, timeout_a;
    logic pc_en_b, ifid_en_b, idex_en_b, exmem_en_b, ifid_flush_b, idex_flush_b, timeout_b;
    logic [5:0] ctl_a, ctl_b;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] lu_cnt_a, miss_cnt_a, flush_cnt_a;
    logic [31:0] lu_cnt_b, miss_cnt_b, flush_cnt_b;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // {pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush}
    assign ctl_a = {pc_en_a, ifid_en_a, idex_en_a, exmem_en_a, ifid_flush_a, idex_flush_a};
    assign ctl_b = {pc_en_b, ifid_en_b, idex_en_b, exmem_en_b, ifid_flush_b, idex_flush_b};

    localparam logic [5:0] C_IDLE   = 6'b111100;
    localparam logic [5:0] C_RESET  = 6'b000011;
    localparam logic [5:0] C_FREEZE = 6'b000000;
    localparam logic [5:0] C_LU     = 6'b001101;
    localparam logic [5:0] C_BRANCH = 6'b111111;

    pipeline_hazard_ctrl #(.MISS_TIMEOUT(64), .REG_AW(5)) dut_a (
        .clk(clk), .rst_n(rst_n), .hit(hit), .mem_access(mem_access),
        .idex_memread(idex_memread), .idex_rt(idex_rt), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
        .branch_taken(branch_taken),
        .pc_en(pc_en_a), .ifid_en(ifid_en_a), .idex_en(idex_en_a), .exmem_en(exmem_en_a),
        .ifid_flush(ifid_flush_a), .idex_flush(idex_flush_a),
`ifdef HAZARD_PERF_CNT_EN
        .lu_stall_cnt(lu_cnt_a), .miss_stall_cnt(miss_cnt_a), .flush_cnt(flush_cnt_a),
`endif
        .miss_timeout(timeout_a)
    );

    pipeline_hazard_ctrl #(.MISS_TIMEOUT(4), .REG_AW(5)) dut_b (
        .clk(clk), .rst_n(rst_n), .hit(hit), .mem_access(mem_access),
        .idex_memread(idex_memread), .idex_rt(idex_rt), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
        .branch_taken(branch_taken),
        .pc_en(pc_en_b), .ifid_en(ifid_en_b), .idex_en(idex_en_b), .exmem_en(exmem_en_b),
        .ifid_flush(ifid_flush_b), .idex_flush(idex_flush_b),
`ifdef HAZARD_PERF_CNT_EN
        .lu_stall_cnt(lu_cnt_b), .miss_stall_cnt(miss_cnt_b), .flush_cnt(flush_cnt_b),
`endif
        .miss_timeout(timeout_b)
    );

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        hit          = 1'b0;
        mem_access   = 1'b0;
        idex_memread = 1'b0;
        idex_rt      = '0;
        ifid_rs      = '0;
        ifid_rt      = '0;
        branch_taken = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        next_cycle();
        @(negedge clk);
        total++;
        if (ctl_a !== C_RESET) begin
            bad++; $display("FAIL reset_ctl got=%b exp=%b", ctl_a, C_RESET);
        end
        total++;
        if (timeout_a !== 1'b0) begin
            bad++; $display("FAIL reset_timeout got=%b exp=0", timeout_a);
        end
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (ctl_a !== C_IDLE) begin
            bad++; $display("FAIL post_reset_idle got=%b exp=%b", ctl_a, C_IDLE);
        end
        next_cycle();
    endtask

    task automatic test_load_use();
        idex_memread = 1'b1; idex_rt = 5'd3; ifid_rs = 5'd3; ifid_rt = 5'd7;
        @(negedge clk);
        total++;
        if (ctl_a !== C_LU) begin
            bad++; $display("FAIL lu_rs_stall got=%b exp=%b", ctl_a, C_LU);
        end
        next_cycle();
        @(negedge clk);
        total++;
        if (ctl_a !== C_IDLE) begin
            bad++; $display("FAIL lu_rs_bubble_once got=%b exp=%b", ctl_a, C_IDLE);
        end
        next_cycle();
        idex_rt = 5'd5; ifid_rs = 5'd1; ifid_rt = 5'd5;
        @(negedge clk);
        total++;
        if (ctl_a !== C_LU) begin
            bad++; $display("FAIL lu_rt_stall got=%b exp=%b", ctl_a, C_LU);
        end
        next_cycle();
        clear_inputs();
        @(negedge clk);
        total++;
        if (ctl_a !== C_IDLE) begin
            bad++; $display("FAIL lu_rt_release got=%b exp=%b", ctl_a, C_IDLE);
        end
        next_cycle();
    endtask

    task automatic test_zero_reg();
        idex_memread = 1'b1; idex_rt = 5'd0; ifid_rs = 5'd0; ifid_rt = 5'd0;
        @(negedge clk);
        total++;
        if (ctl_a !== C_IDLE) begin
            bad++; $display("FAIL zero_reg got=%b exp=%b", ctl_a, C_IDLE);
        end
        next_cycle();
        idex_memread = 1'b0; idex_rt = 5'd3; ifid_rs = 5'd3;
        @(negedge clk);
        total++;
        if (ctl_a !== C_IDLE) begin
            bad++; $display("FAIL no_load_no_stall got=%b exp=%b", ctl_a, C_IDLE);
        end
        next_cycle();
        clear_inputs();
    endtask

    task automatic test_miss_recovery();
        mem_access = 1'b1; hit = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            total++;
            if (ctl_a !== C_FREEZE) begin
                bad++; $display("FAIL miss_freeze_%0d got=%b exp=%b", i, ctl_a, C_FREEZE);
            end
            next_cycle();
        end
        hit = 1'b1;
        @(negedge clk);
        total++;
        if (ctl_a !== C_IDLE) begin
            bad++; $display("FAIL miss_recover got=%b exp=%b", ctl_a, C_IDLE);
        end
        total++;
        if (timeout_a !== 1'b0) begin
            bad++; $display("FAIL miss_no_timeout got=%b exp=0", timeout_a);
        end
        next_cycle();
        clear_inputs();
        next_cycle();
    endtask

    task automatic test_priorities();
        branch_taken = 1'b1; idex_memread = 1'b1; idex_rt = 5'd3; ifid_rs = 5'd3;
        @(negedge clk);
        total++;
        if (ctl_a !== C_BRANCH) begin
            bad++; $display("FAIL branch_over_lu got=%b exp=%b", ctl_a, C_BRANCH);
        end
        next_cycle();
        mem_access = 1'b1; hit = 1'b0;
        @(negedge clk);
        total++;
        if (ctl_a !== C_FREEZE) begin
            bad++; $display("FAIL miss_over_branch got=%b exp=%b", ctl_a, C_FREEZE);
        end
        next_cycle();
        mem_access = 1'b0;
        @(negedge clk);
        total++;
        if (ctl_a !== C_BRANCH) begin
            bad++; $display("FAIL branch_after_miss got=%b exp=%b", ctl_a, C_BRANCH);
        end
        next_cycle();
        branch_taken = 1'b0; mem_access = 1'b1;
        @(negedge clk);
        total++;
        if (ctl_a !== C_FREEZE) begin
            bad++; $display("FAIL miss_over_lu got=%b exp=%b", ctl_a, C_FREEZE);
        end
        next_cycle();
        mem_access = 1'b0;
        @(negedge clk);
        total++;
        if (ctl_a !== C_LU) begin
            bad++; $display("FAIL lu_after_miss got=%b exp=%b", ctl_a, C_LU);
        end
        next_cycle();
        @(negedge clk);
        total++;
        if (ctl_a !== C_IDLE) begin
            bad++; $display("FAIL lu_after_miss_bubble got=%b exp=%b", ctl_a, C_IDLE);
        end
        next_cycle();
        clear_inputs();
        next_cycle();
    endtask

    task automatic test_timeout();
        rst_n = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        mem_access = 1'b1; hit = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            total++;
            if (timeout_b !== (i >= 6)) begin
                bad++; $display("FAIL timeout_cycle_%0d got=%b exp=%b", i, timeout_b, (i >= 6));
            end
            total++;
            if (ctl_b !== C_FREEZE) begin
                bad++; $display("FAIL timeout_freeze_%0d got=%b exp=%b", i, ctl_b, C_FREEZE);
            end
            next_cycle();
        end
        total++;
        if (timeout_a !== 1'b0) begin
            bad++; $display("FAIL default_no_timeout got=%b exp=0", timeout_a);
        end
        hit = 1'b1;
        @(negedge clk);
        total++;
        if (ctl_b !== C_IDLE || timeout_b !== 1'b1) begin
            bad++; $display("FAIL timeout_sticky_hit ctl=%b to=%b exp ctl=%b to=1", ctl_b, timeout_b, C_IDLE);
        end
        next_cycle();
        clear_inputs();
        next_cycle();
        next_cycle();
        @(negedge clk);
        total++;
        if (timeout_b !== 1'b1) begin
            bad++; $display("FAIL timeout_held got=%b exp=1", timeout_b);
        end
        next_cycle();
        rst_n = 1'b0;
        @(negedge clk);
        total++;
        if (timeout_b !== 1'b0) begin
            bad++; $display("FAIL timeout_in_reset got=%b exp=0", timeout_b);
        end
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (timeout_b !== 1'b0) begin
            bad++; $display("FAIL timeout_after_reset got=%b exp=0", timeout_b);
        end
        next_cycle();
    endtask

    task automatic test_reset_mid();
        mem_access = 1'b1; hit = 1'b0;
        repeat (3) next_cycle();
        rst_n = 1'b0;
        @(negedge clk);
        total++;
        if (ctl_a !== C_RESET || timeout_a !== 1'b0) begin
            bad++; $display("FAIL reset_mid_miss ctl=%b to=%b exp ctl=%b to=0", ctl_a, timeout_a, C_RESET);
        end
        next_cycle();
        rst_n = 1'b1; mem_access = 1'b0;
        @(negedge clk);
        total++;
        if (ctl_a !== C_IDLE) begin
            bad++; $display("FAIL reset_mid_miss_release got=%b exp=%b", ctl_a, C_IDLE);
        end
        next_cycle();
        // Wait counter restarted from 0: dut_b needs four fresh wait cycles to time out.
        mem_access = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            total++;
            if (timeout_b !== (i >= 6)) begin
                bad++; $display("FAIL reset_mid_cnt_%0d got=%b exp=%b", i, timeout_b, (i >= 6));
            end
            next_cycle();
        end
        clear_inputs();
        rst_n = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        idex_memread = 1'b1; idex_rt = 5'd4; ifid_rs = 5'd4;
        @(negedge clk);
        total++;
        if (ctl_a !== C_LU) begin
            bad++; $display("FAIL reset_mid_lu_stall got=%b exp=%b", ctl_a, C_LU);
        end
        next_cycle();
        rst_n = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        clear_inputs();
        @(negedge clk);
        total++;
        if (ctl_a !== C_IDLE) begin
            bad++; $display("FAIL reset_mid_lu_release got=%b exp=%b", ctl_a, C_IDLE);
        end
        next_cycle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        test_reset();
        test_load_use();
        test_zero_reg();
        test_miss_recovery();
        test_priorities();
        test_timeout();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
